// File: rtl/rvfi_retire_tracker.sv
// Single-retire RVFI tracker: pairs each issued instruction with its commit and
// emits one registered RVFI retirement per commit, with order, trap and interrupt tagging.
module rvfi_retire_tracker #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            issue_valid,
  input  logic [XLEN-1:0] issue_pc,
  input  logic [ILEN-1:0] issue_insn,
  output logic            issue_ready,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_next_pc,
  input  logic            commit_trap,
  input  logic            commit_halt,
  input  logic            irq_entry,
  output logic            rvfi_valid,
  output logic [63:0]     rvfi_order,
  output logic [ILEN-1:0] rvfi_insn,
  output logic            rvfi_trap,
  output logic            rvfi_halt,
  output logic            rvfi_intr,
  output logic [1:0]      rvfi_mode,
  output logic [1:0]      rvfi_ixl,
  output logic [XLEN-1:0] rvfi_pc_rdata,
  output logic [XLEN-1:0] rvfi_pc_wdata,
  output logic            protocol_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PEND   = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]      state_reg, state_next;
  logic [XLEN-1:0] pc_reg;
  logic [ILEN-1:0] insn_reg;
  logic [63:0]     order_next_reg;
  logic            redirect_reg;
  logic            commit_fire;
  logic            issue_take;

  assign commit_fire = (state_reg == PEND) && commit_valid;
  assign issue_take  = issue_valid && issue_ready;

  assign rvfi_mode = 2'd3;
  assign rvfi_ixl  = (XLEN == 64) ? 2'd2 : 2'd1;

  // Back-to-back issue is allowed in the same cycle the pending instruction retires.
  always_comb begin
    issue_ready = 1'b0;
    case (state_reg)
      IDLE:    issue_ready = 1'b1;
      PEND:    issue_ready = commit_valid && !commit_halt;
      default: issue_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (issue_valid) state_next = PEND;
      PEND: begin
        if (commit_valid) begin
          if (commit_halt)     state_next = HALTED;
          else if (issue_take) state_next = PEND;
          else                 state_next = IDLE;
        end
      end
      default: state_next = state_reg;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      pc_reg         <= '0;
      insn_reg       <= '0;
      order_next_reg <= '0;
      redirect_reg   <= 1'b0;
      protocol_err   <= 1'b0;
      rvfi_valid     <= 1'b0;
      rvfi_order     <= '0;
      rvfi_insn      <= '0;
      rvfi_trap      <= 1'b0;
      rvfi_halt      <= 1'b0;
      rvfi_intr      <= 1'b0;
      rvfi_pc_rdata  <= '0;
      rvfi_pc_wdata  <= '0;
    end else begin
      state_reg  <= state_next;
      rvfi_valid <= commit_fire;
      if (issue_take) begin
        pc_reg   <= issue_pc;
        insn_reg <= issue_insn;
      end
      if (commit_fire) begin
        rvfi_order     <= order_next_reg;
        rvfi_insn      <= insn_reg;
        rvfi_pc_rdata  <= pc_reg;
        rvfi_pc_wdata  <= commit_next_pc;
        rvfi_trap      <= commit_trap;
        rvfi_halt      <= commit_halt;
        rvfi_intr      <= redirect_reg;
        order_next_reg <= order_next_reg + 64'd1;
      end
      // The retirement consumes the redirect flag; a coincident irq tags the following one.
      if (state_reg != HALTED) begin
        if (commit_fire)    redirect_reg <= commit_trap || irq_entry;
        else if (irq_entry) redirect_reg <= 1'b1;
      end
      if (commit_valid && (state_reg != PEND)) protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rvfi_retire_tracker.sv
// Bench for rvfi_retire_tracker: a per-cycle reference model checked on every falling
// edge, plus directed scenarios with literal expected values.
module tb_rvfi_retire_tracker;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        issue_valid;
  logic [31:0] issue_pc;
  logic [31:0] issue_insn;
  logic        issue_ready;
  logic        commit_valid;
  logic [31:0] commit_next_pc;
  logic        commit_trap;
  logic        commit_halt;
  logic        irq_entry;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap;
  logic        rvfi_halt;
  logic        rvfi_intr;
  logic [1:0]  rvfi_mode;
  logic [1:0]  rvfi_ixl;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_pc_wdata;
  logic        protocol_err;

  int n_checks = 0;
  int n_fail   = 0;

  rvfi_retire_tracker #(.XLEN(32), .ILEN(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_pc(issue_pc), .issue_insn(issue_insn),
    .issue_ready(issue_ready),
    .commit_valid(commit_valid), .commit_next_pc(commit_next_pc),
    .commit_trap(commit_trap), .commit_halt(commit_halt), .irq_entry(irq_entry),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
    .rvfi_mode(rvfi_mode), .rvfi_ixl(rvfi_ixl),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pending slot, a halted flag and the expected visible retirement.
  typedef struct {
    logic        valid;
    logic [63:0] order;
    logic [31:0] insn, rdata, wdata;
    logic        trap, halt, intr;
  } retire_t;

  retire_t     m_out;
  logic        m_pend, m_halted, m_flag, m_err;
  logic [31:0] m_pc, m_insn;
  logic [63:0] m_order;

  task automatic model_reset();
    m_out    = '{valid: 1'b0, order: 64'd0, insn: 32'd0, rdata: 32'd0, wdata: 32'd0,
                 trap: 1'b0, halt: 1'b0, intr: 1'b0};
    m_pend   = 1'b0;
    m_halted = 1'b0;
    m_flag   = 1'b0;
    m_err    = 1'b0;
    m_pc     = '0;
    m_insn   = '0;
    m_order  = '0;
  endtask

  initial model_reset();

  always @(negedge clock) begin
    logic ready, fire;
    if (!reset_n) model_reset();
    cmp("rvfi_valid", 64'(rvfi_valid), 64'(m_out.valid));
    cmp("rvfi_order", rvfi_order, m_out.order);
    cmp("rvfi_insn", 64'(rvfi_insn), 64'(m_out.insn));
    cmp("rvfi_pc_rdata", 64'(rvfi_pc_rdata), 64'(m_out.rdata));
    cmp("rvfi_pc_wdata", 64'(rvfi_pc_wdata), 64'(m_out.wdata));
    cmp("rvfi_trap", 64'(rvfi_trap), 64'(m_out.trap));
    cmp("rvfi_halt", 64'(rvfi_halt), 64'(m_out.halt));
    cmp("rvfi_intr", 64'(rvfi_intr), 64'(m_out.intr));
    cmp("rvfi_mode", 64'(rvfi_mode), 64'd3);
    cmp("rvfi_ixl", 64'(rvfi_ixl), 64'd1);
    cmp("protocol_err", 64'(protocol_err), 64'(m_err));
    ready = !m_halted && (!m_pend || (commit_valid && !commit_halt));
    cmp("issue_ready", 64'(issue_ready), 64'(ready));
    if (reset_n) begin
      fire = m_pend && commit_valid;
      m_out.valid = fire;
      if (fire) begin
        m_out.order = m_order;
        m_out.insn  = m_insn;
        m_out.rdata = m_pc;
        m_out.wdata = commit_next_pc;
        m_out.trap  = commit_trap;
        m_out.halt  = commit_halt;
        m_out.intr  = m_flag;
        m_order     = m_order + 64'd1;
      end
      if (commit_valid && !m_pend) m_err = 1'b1;
      if (!m_halted) m_flag = fire ? (commit_trap | irq_entry) : (m_flag | irq_entry);
      if (fire) begin
        m_pend = 1'b0;
        if (commit_halt) m_halted = 1'b1;
      end
      if (issue_valid && ready) begin
        m_pend = 1'b1;
        m_pc   = issue_pc;
        m_insn = issue_insn;
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_pc = '0; issue_insn = '0;
    commit_valid = 0; commit_next_pc = '0; commit_trap = 0; commit_halt = 0;
    irq_entry = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    cyc(); cyc();
    reset_n = 1'b1;
  endtask

  task automatic drive_issue(input logic [31:0] pc, input logic [31:0] insn);
    issue_valid = 1; issue_pc = pc; issue_insn = insn;
  endtask

  task automatic drive_commit(input logic [31:0] npc, input logic trap, input logic halt);
    commit_valid = 1; commit_next_pc = npc; commit_trap = trap; commit_halt = halt;
  endtask

  initial begin
    do_reset();

    // Single issue, commit two cycles later
    drive_issue(32'h100, 32'h0000_0013); cyc(); idle_inputs();
    cyc();
    drive_commit(32'h104, 0, 0); cyc(); idle_inputs();
    cmp("t1_valid", 64'(rvfi_valid), 64'd1);
    cmp("t1_order", rvfi_order, 64'd0);
    cmp("t1_rdata", 64'(rvfi_pc_rdata), 64'h100);
    cmp("t1_wdata", 64'(rvfi_pc_wdata), 64'h104);
    cmp("t1_insn", 64'(rvfi_insn), 64'h13);
    cmp("t1_intr", 64'(rvfi_intr), 64'd0);
    cyc();
    cmp("t1_single_pulse", 64'(rvfi_valid), 64'd0);

    // Back-to-back issue in the commit cycle
    do_reset();
    drive_issue(32'h100, 32'h0000_0013); cyc();
    drive_commit(32'h104, 0, 0); drive_issue(32'h104, 32'h0010_0093); cyc();
    cmp("t2_order0", rvfi_order, 64'd0);
    cmp("t2_rdata0", 64'(rvfi_pc_rdata), 64'h100);
    drive_commit(32'h108, 0, 0); drive_issue(32'h108, 32'h0020_0113); cyc();
    cmp("t2_valid1", 64'(rvfi_valid), 64'd1);
    cmp("t2_order1", rvfi_order, 64'd1);
    cmp("t2_rdata1", 64'(rvfi_pc_rdata), 64'h104);
    idle_inputs(); drive_commit(32'h10c, 0, 0); cyc(); idle_inputs();
    cmp("t2_valid2", 64'(rvfi_valid), 64'd1);
    cmp("t2_order2", rvfi_order, 64'd2);
    cmp("t2_rdata2", 64'(rvfi_pc_rdata), 64'h108);
    cmp("t2_insn2", 64'(rvfi_insn), 64'h0020_0113);

    // Trap redirect tags the following retirement only
    drive_issue(32'h200, 32'h0000_0073); cyc(); idle_inputs();
    drive_commit(32'h80, 1, 0); cyc(); idle_inputs();
    cmp("t3_trap", 64'(rvfi_trap), 64'd1);
    drive_issue(32'h80, 32'h0000_0013); cyc(); idle_inputs();
    drive_commit(32'h84, 0, 0); cyc(); idle_inputs();
    cmp("t3_intr_after_trap", 64'(rvfi_intr), 64'd1);
    cmp("t3_rdata", 64'(rvfi_pc_rdata), 64'h80);
    drive_issue(32'h84, 32'h0000_0013); cyc(); idle_inputs();
    drive_commit(32'h88, 0, 0); cyc(); idle_inputs();
    cmp("t3_intr_cleared", 64'(rvfi_intr), 64'd0);

    // irq in IDLE, then a stray commit in IDLE
    irq_entry = 1; cyc(); idle_inputs();
    drive_issue(32'h300, 32'h0000_0013); cyc(); idle_inputs();
    drive_commit(32'h304, 0, 0); cyc(); idle_inputs();
    cmp("t4_intr_irq", 64'(rvfi_intr), 64'd1);
    cyc();
    drive_commit(32'h400, 0, 0); cyc(); idle_inputs();
    cmp("t4_protocol_err", 64'(protocol_err), 64'd1);
    cmp("t4_no_emit", 64'(rvfi_valid), 64'd0);

    // Irq coincident with a commit applies to the next retirement
    drive_issue(32'h500, 32'h0000_0013); cyc(); idle_inputs();
    drive_commit(32'h504, 0, 0); drive_issue(32'h504, 32'h13); irq_entry = 1; cyc();
    idle_inputs();
    cmp("t5_intr_same", 64'(rvfi_intr), 64'd0);
    drive_commit(32'h508, 0, 0); cyc(); idle_inputs();
    cmp("t5_intr_next", 64'(rvfi_intr), 64'd1);

    // Halt, then everything is ignored except protocol errors
    do_reset();
    drive_issue(32'h600, 32'h0010_0073); cyc(); idle_inputs();
    drive_commit(32'h604, 0, 1); drive_issue(32'h604, 32'h13); cyc(); idle_inputs();
    cmp("t6_halt", 64'(rvfi_halt), 64'd1);
    cmp("t6_ready_after_halt", 64'(issue_ready), 64'd0);
    drive_issue(32'h700, 32'h13); irq_entry = 1; cyc(); idle_inputs();
    drive_commit(32'h704, 0, 0); cyc(); idle_inputs();
    cmp("t6_halted_no_emit", 64'(rvfi_valid), 64'd0);
    cmp("t6_halted_err", 64'(protocol_err), 64'd1);

    // Reset mid-PEND discards the pending instruction
    do_reset();
    drive_issue(32'h800, 32'h13); cyc(); idle_inputs();
    drive_commit(32'h804, 0, 0); cyc(); idle_inputs();
    drive_issue(32'h900, 32'h13); cyc(); idle_inputs();
    reset_n = 1'b0; #1;
    cmp("t7_rst_order", rvfi_order, 64'd0);
    cmp("t7_rst_rdata", 64'(rvfi_pc_rdata), 64'd0);
    cmp("t7_rst_ready", 64'(issue_ready), 64'd1);
    cyc(); reset_n = 1'b1;
    drive_commit(32'h999, 0, 0); cyc(); idle_inputs();
    cmp("t7_discarded", 64'(rvfi_valid), 64'd0);
    do_reset();
    drive_issue(32'ha00, 32'h13); cyc(); idle_inputs();
    drive_commit(32'ha04, 0, 0); cyc(); idle_inputs();
    cmp("t7_order_restart", rvfi_order, 64'd0);
    cmp("t7_intr_restart", 64'(rvfi_intr), 64'd0);

    // Order counter wrap via preload
    dut.order_next_reg = 64'hFFFF_FFFF_FFFF_FFFF;
    m_order = 64'hFFFF_FFFF_FFFF_FFFF;
    drive_issue(32'hb00, 32'h13); cyc(); idle_inputs();
    drive_commit(32'hb04, 0, 0); drive_issue(32'hb04, 32'h13); cyc(); idle_inputs();
    cmp("t8_order_max", rvfi_order, 64'hFFFF_FFFF_FFFF_FFFF);
    drive_commit(32'hb08, 0, 0); cyc(); idle_inputs();
    cmp("t8_order_wrap", rvfi_order, 64'd0);
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
